store_queue_fwd: RTL
====================

Name: store_queue_fwd

Overview:
Circular, parametrised store queue that succeeds the fixed-size storeq. Stores enter in program order at dispatch and receive address and data at execute. They become committed at ROB retire and then drain to the D-cache one per cycle through a valid/ready handshake. Loads search the queue each cycle for store-to-load forwarding against older stores, with byte-accurate overlap checking. A branch flush discards only uncommitted entries.

Parameters:
SQ_DEPTH, 16, number of entries; power of two, at least 4
N_WAY, 2, dispatch/execute/retire/load lanes per cycle
XLEN, 32, address and data width
TAG_W, 6, load destination tag width
PTR_W, $clog2(SQ_DEPTH), slot index width; pointers carry one extra wrap bit

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
dis_num  in  $clog2(N_WAY)+1  stores dispatched this cycle
dis_pos  out  N_WAY x PTR_W  slot assigned to dispatch lane i; equals tail+i
free_cnt  out  PTR_W+1  free entries, registered
ex_valid  in  N_WAY  execute write valid per lane
ex_pos  in  N_WAY x PTR_W  slot being written
ex_addr / ex_data  in  N_WAY x XLEN  store address / data
ex_size  in  N_WAY x 2  MEM_SIZE encoding: BYTE=0, HALF=1, WORD=2
ret_num  in  $clog2(N_WAY)+1  stores retired by the ROB this cycle
flush  in  1  branch mispredict squash
dc_valid  out  1  drain request valid
dc_addr / dc_data  out  XLEN  drain address / data
dc_size  out  2  drain size
dc_ready  in  1  D-cache accepts drain
ld_valid  in  N_WAY  load lookup valid
ld_age  in  N_WAY x (PTR_W+1)  tail pointer snapshot taken at the load's dispatch
ld_addr  in  N_WAY x XLEN  load address
ld_size  in  N_WAY x 2  load size
ld_unsigned  in  N_WAY  1 = zero-extend, 0 = sign-extend
ld_tag  in  N_WAY x TAG_W  destination tag
fwd_hit  out  N_WAY  forwarded data valid
fwd_stall  out  N_WAY  load must replay
fwd_data  out  N_WAY x XLEN  extended forwarded value
fwd_tag  out  N_WAY x TAG_W  echo of ld_tag

Behaviour:
- Per-entry state: FREE, ALLOC, EXEC, COMMIT. A committed entry retains its EXEC data. Three pointers of PTR_W+1 bits: head (oldest), cmt (first uncommitted), tail (next free). Wrap: pointer increment carries into the wrap bit. Occupancy is tail-head.
- Reset: every entry FREE, all pointers 0, free_cnt=SQ_DEPTH, dc_valid=0, all fwd_* outputs 0.
- Dispatch: lanes 0..dis_num-1 take slots tail..tail+dis_num-1 and move to ALLOC; tail advances next cycle. dis_num > free_cnt is illegal and triggers an assertion. Full queue: free_cnt=0.
- Execute: ex_valid[i] writes addr, data and size into slot ex_pos[i] and moves it to EXEC. A write to a FREE slot is ignored and asserts.
- Retire: ret_num entries starting at cmt move to COMMIT; cmt advances. Every retired entry must already be in EXEC (assertion).
- Drain: dc_valid=1 when head is in COMMIT; dc_* present head's fields combinationally from registers. When dc_valid && dc_ready, the entry goes FREE and head advances; free_cnt rises by 1 next cycle. At most one drain per cycle.
- Flush: tail <= cmt; all ALLOC/EXEC entries go FREE. Dispatch and execute in the same cycle are ignored. Retire in the same cycle is honoured first, because those stores are older than the branch. Drain continues unaffected.
- Simultaneous events: free_cnt_next = free_cnt - dis_num + drained (+ squashed on flush).
- Forwarding, combinational, lanes independent: candidates are valid entries from head up to but excluding ld_age, scanned youngest to oldest. The first entry whose byte range overlaps the load's range is the match.
  - Match in EXEC/COMMIT and fully covering the load: fwd_hit=1. Data is extracted by address offset, then sign- or zero-extended to XLEN.
  - Partial overlap: fwd_stall=1.
  - No match: both outputs 0; the load uses the cache.
  - ld_age==head: no candidates.
- Unexecuted older stores: in default mode, any ALLOC entry older than the load forces fwd_stall=1 regardless of address.
- Reset mid-operation clears everything, including committed undrained stores.

Optional Feature:
SQ_SPEC_LOAD_EN
- Defined: ALLOC entries are skipped during the forwarding search, so loads speculate past unknown-address stores. A 1-bit ld_order_viol output pulses when an execute write's bytes overlap the range of any load that searched past that entry since its dispatch. A per-entry "skipped" bit records this.
- Undefined: conservative stall as above; ld_order_viol is absent.

Test Plan:
- Reset, then dispatch 16 stores, 1 per cycle -> free_cnt 16..0; dis_pos 0..15; the 17th dispatch fires the assertion.
- Store WORD 0x1000=0xDEADBEEF executed, then load BYTE 0x1003 unsigned with a younger ld_age -> fwd_hit=1, fwd_data=0x000000DE; signed -> 0xFFFFFFDE.
- Store BYTE 0x2001=0x80, then load WORD 0x2000 -> fwd_stall=1, fwd_hit=0.
- Two stores to 0x3000 (0x11, then 0x22), load after both -> fwd_data=0x22; load with ld_age between them -> 0x11.
- 3 committed plus 2 executed stores, flush -> tail=cmt; free_cnt = DEPTH-3; drains complete with dc_ready alternating 0/1; head wraps from 15 to 0 and the wrap bit toggles.
- Retire 2 and flush in the same cycle -> both retired stores drain; uncommitted stores are squashed.

Source files
------------

// File: rtl/store_queue_fwd.sv
// rtl/store_queue_fwd.sv - circular store queue with byte-accurate store-to-load forwarding
// Optional feature macro: SQ_SPEC_LOAD_EN (loads search past unexecuted stores; adds ld_order_viol).
// Ports: clock, reset (sync, active-high)
//        dis_num -> dis_pos, free_cnt       : in-order allocation at the tail
//        ex_valid/ex_pos/ex_addr/ex_data/ex_size : execute write of a store's fields
//        ret_num, flush                      : commit from cmt pointer, squash of uncommitted
//        dc_valid/dc_addr/dc_data/dc_size/dc_ready : one drain per cycle from head
//        ld_valid/ld_age/ld_addr/ld_size/ld_unsigned/ld_tag -> fwd_hit/fwd_stall/fwd_data/fwd_tag
module store_queue_fwd #(
   parameter int SQ_DEPTH = 16,
   parameter int N_WAY    = 2,
   parameter int XLEN     = 32,
   parameter int TAG_W    = 6,
   parameter int PTR_W    = $clog2(SQ_DEPTH)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [$clog2(N_WAY):0]          dis_num,
   output logic [N_WAY-1:0][PTR_W-1:0]     dis_pos,
   output logic [PTR_W:0]                  free_cnt,
   input  logic [N_WAY-1:0]                ex_valid,
   input  logic [N_WAY-1:0][PTR_W-1:0]     ex_pos,
   input  logic [N_WAY-1:0][XLEN-1:0]      ex_addr,
   input  logic [N_WAY-1:0][XLEN-1:0]      ex_data,
   input  logic [N_WAY-1:0][1:0]           ex_size,
   input  logic [$clog2(N_WAY):0]          ret_num,
   input  logic                            flush,
   output logic                            dc_valid,
   output logic [XLEN-1:0]                 dc_addr,
   output logic [XLEN-1:0]                 dc_data,
   output logic [1:0]                      dc_size,
   input  logic                            dc_ready,
   input  logic [N_WAY-1:0]                ld_valid,
   input  logic [N_WAY-1:0][PTR_W:0]       ld_age,
   input  logic [N_WAY-1:0][XLEN-1:0]      ld_addr,
   input  logic [N_WAY-1:0][1:0]           ld_size,
   input  logic [N_WAY-1:0]                ld_unsigned,
   input  logic [N_WAY-1:0][TAG_W-1:0]     ld_tag,
`ifdef SQ_SPEC_LOAD_EN
   output logic                            ld_order_viol,
`endif
   output logic [N_WAY-1:0]                fwd_hit,
   output logic [N_WAY-1:0]                fwd_stall,
   output logic [N_WAY-1:0][XLEN-1:0]      fwd_data,
   output logic [N_WAY-1:0][TAG_W-1:0]     fwd_tag
);
   localparam int NW = $clog2(N_WAY) + 1;

   typedef enum logic [1:0] {S_FREE, S_ALLOC, S_EXEC, S_COMMIT} st_e;

   st_e             st_q [SQ_DEPTH];
   st_e             st_d [SQ_DEPTH];
   logic [XLEN-1:0] addr_q [SQ_DEPTH];
   logic [XLEN-1:0] data_q [SQ_DEPTH];
   logic [1:0]      size_q [SQ_DEPTH];
   logic [PTR_W:0]  head_q, cmt_q, tail_q, head_d, cmt_d, tail_d;
   logic            drain;

   function automatic logic [XLEN-1:0] nbytes(input logic [1:0] s);
      case (s)
         2'd0:    return XLEN'(1);
         2'd1:    return XLEN'(2);
         default: return XLEN'(4);
      endcase
   endfunction

   // Half-open byte ranges [a0,a1) and [b0,b1) share at least one byte.
   function automatic logic overlap(input logic [XLEN-1:0] a0, a1, b0, b1);
      return (a0 < b1) && (b0 < a1);
   endfunction

   always_comb begin
      for (int i = 0; i < N_WAY; i++) dis_pos[i] = tail_q[PTR_W-1:0] + PTR_W'(i);
   end

   assign dc_valid = (st_q[head_q[PTR_W-1:0]] == S_COMMIT);
   assign dc_addr  = addr_q[head_q[PTR_W-1:0]];
   assign dc_data  = data_q[head_q[PTR_W-1:0]];
   assign dc_size  = size_q[head_q[PTR_W-1:0]];
   assign drain    = dc_valid && dc_ready;

   // Next-state: dispatch/execute (dropped on flush), retire (always honoured,
   // so it lands before the squash), flush squash, then drain of the head.
   always_comb begin
      logic [PTR_W-1:0] idx;
      st_d   = st_q;
      head_d = head_q;
      cmt_d  = cmt_q + (PTR_W+1)'(ret_num);
      tail_d = tail_q;
      if (!flush) begin
         for (int i = 0; i < N_WAY; i++)
            if (NW'(i) < dis_num) st_d[dis_pos[i]] = S_ALLOC;
         tail_d = tail_q + (PTR_W+1)'(dis_num);
         for (int i = 0; i < N_WAY; i++)
            if (ex_valid[i] && (st_q[ex_pos[i]] == S_ALLOC || st_q[ex_pos[i]] == S_EXEC))
               st_d[ex_pos[i]] = S_EXEC;
      end
      for (int i = 0; i < N_WAY; i++) begin
         idx = cmt_q[PTR_W-1:0] + PTR_W'(i);
         if (NW'(i) < ret_num) st_d[idx] = S_COMMIT;
      end
      if (flush) begin
         for (int j = 0; j < SQ_DEPTH; j++)
            if (st_d[j] == S_ALLOC || st_d[j] == S_EXEC) st_d[j] = S_FREE;
         tail_d = cmt_d;
      end
      if (drain) begin
         st_d[head_q[PTR_W-1:0]] = S_FREE;
         head_d = head_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int j = 0; j < SQ_DEPTH; j++) st_q[j] <= S_FREE;
         head_q   <= '0;
         cmt_q    <= '0;
         tail_q   <= '0;
         free_cnt <= (PTR_W+1)'(SQ_DEPTH);
      end else begin
         st_q     <= st_d;
         head_q   <= head_d;
         cmt_q    <= cmt_d;
         tail_q   <= tail_d;
         free_cnt <= (PTR_W+1)'(SQ_DEPTH) - (tail_d - head_d);
         assert (flush || (PTR_W+1)'(dis_num) <= free_cnt);
         for (int i = 0; i < N_WAY; i++) begin
            assert (flush || !ex_valid[i] || st_q[ex_pos[i]] != S_FREE);
            if (NW'(i) < ret_num)
               assert (st_q[cmt_q[PTR_W-1:0] + PTR_W'(i)] == S_EXEC);
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < N_WAY; i++)
         if (!reset && !flush && ex_valid[i] &&
             (st_q[ex_pos[i]] == S_ALLOC || st_q[ex_pos[i]] == S_EXEC)) begin
            addr_q[ex_pos[i]] <= ex_addr[i];
            data_q[ex_pos[i]] <= ex_data[i];
            size_q[ex_pos[i]] <= ex_size[i];
         end
   end

`ifdef SQ_SPEC_LOAD_EN
   logic [N_WAY-1:0][SQ_DEPTH-1:0] skip_mark;
   logic [SQ_DEPTH-1:0]            skip_q, skip_d;
   logic [XLEN-1:0]                sk_lo_q [SQ_DEPTH], sk_hi_q [SQ_DEPTH];
   logic [XLEN-1:0]                sk_lo_d [SQ_DEPTH], sk_hi_d [SQ_DEPTH];
`endif

   // Forwarding search: walk oldest to youngest over [head, ld_age); the last
   // overlapping executed entry seen is the youngest older match.
   always_comb begin
      logic [PTR_W:0]   span;
      logic [PTR_W-1:0] idx, m_idx;
      logic [XLEN-1:0]  lo, hi, raw;
      logic             found, full;
`ifdef SQ_SPEC_LOAD_EN
      int               m_k;
      skip_mark = '0;
`else
      logic             any_alloc;
`endif
      for (int l = 0; l < N_WAY; l++) begin
         span  = ld_age[l] - head_q;
         lo    = ld_addr[l];
         hi    = ld_addr[l] + nbytes(ld_size[l]);
         found = 1'b0;
         m_idx = '0;
`ifdef SQ_SPEC_LOAD_EN
         m_k = -1;
`else
         any_alloc = 1'b0;
`endif
         for (int k = 0; k < SQ_DEPTH; k++) begin
            idx = head_q[PTR_W-1:0] + PTR_W'(k);
            if ((PTR_W+1)'(k) < span) begin
               if ((st_q[idx] == S_EXEC || st_q[idx] == S_COMMIT) &&
                   overlap(addr_q[idx], addr_q[idx] + nbytes(size_q[idx]), lo, hi)) begin
                  found = 1'b1;
                  m_idx = idx;
`ifdef SQ_SPEC_LOAD_EN
                  m_k   = k;
`endif
               end
`ifndef SQ_SPEC_LOAD_EN
               if (st_q[idx] == S_ALLOC) any_alloc = 1'b1;
`endif
            end
         end
         full = found && (addr_q[m_idx] <= lo) && (hi <= addr_q[m_idx] + nbytes(size_q[m_idx]));
         raw  = data_q[m_idx] >> {lo[1:0] - addr_q[m_idx][1:0], 3'b000};
         case (ld_size[l])
            2'd0:    raw = {{(XLEN-8){raw[7] & ~ld_unsigned[l]}}, raw[7:0]};
            2'd1:    raw = {{(XLEN-16){raw[15] & ~ld_unsigned[l]}}, raw[15:0]};
            default: ;
         endcase
`ifdef SQ_SPEC_LOAD_EN
         fwd_hit[l]   = ld_valid[l] && full;
         fwd_stall[l] = ld_valid[l] && found && !full;
         // Unexecuted entries younger than the match were searched past.
         for (int k = 0; k < SQ_DEPTH; k++) begin
            idx = head_q[PTR_W-1:0] + PTR_W'(k);
            if ((PTR_W+1)'(k) < span && st_q[idx] == S_ALLOC && k > m_k)
               skip_mark[l][idx] = ld_valid[l];
         end
`else
         fwd_hit[l]   = ld_valid[l] && !any_alloc && full;
         fwd_stall[l] = ld_valid[l] && (any_alloc || (found && !full));
`endif
         fwd_data[l] = fwd_hit[l] ? raw : '0;
         fwd_tag[l]  = ld_valid[l] ? ld_tag[l] : '0;
      end
   end

`ifdef SQ_SPEC_LOAD_EN
   // Each skipped entry keeps the byte envelope of every load that passed it.
   always_comb begin
      skip_d  = skip_q;
      sk_lo_d = sk_lo_q;
      sk_hi_d = sk_hi_q;
      for (int j = 0; j < SQ_DEPTH; j++)
         if (st_q[j] == S_FREE) skip_d[j] = 1'b0;
      for (int l = 0; l < N_WAY; l++)
         for (int j = 0; j < SQ_DEPTH; j++)
            if (skip_mark[l][j]) begin
               sk_lo_d[j] = (skip_d[j] && sk_lo_d[j] < ld_addr[l]) ? sk_lo_d[j] : ld_addr[l];
               sk_hi_d[j] = (skip_d[j] && sk_hi_d[j] > ld_addr[l] + nbytes(ld_size[l]))
                            ? sk_hi_d[j] : ld_addr[l] + nbytes(ld_size[l]);
               skip_d[j]  = 1'b1;
            end
      ld_order_viol = 1'b0;
      for (int i = 0; i < N_WAY; i++)
         if (!flush && ex_valid[i] && skip_q[ex_pos[i]] &&
             overlap(ex_addr[i], ex_addr[i] + nbytes(ex_size[i]),
                     sk_lo_q[ex_pos[i]], sk_hi_q[ex_pos[i]]))
            ld_order_viol = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         skip_q <= '0;
      end else begin
         skip_q  <= skip_d;
         sk_lo_q <= sk_lo_d;
         sk_hi_q <= sk_hi_d;
      end
   end
`endif
endmodule
